// File: rtl/hacd_pkg.sv
// ---------------------------------------------------------------------------
// hacd_pkg
// Shared types and constants for the hawk AXI-style write path.
//   axi_wr_reqpkt_t  : master -> slave request {addr, data, strb, awvalid, wvalid}
//   axi_wr_rdypkt_t  : slave -> master ready   {awready, wready}
//   axi_wr_resppkt_t : slave -> master B       {bresp, bvalid}
//   axi_wr_pld_t     : store-port payload      {addr, data, strb}
//   axiwr_slv_st_t   : write-slave commit FSM states
// ---------------------------------------------------------------------------
package hacd_pkg;

    localparam logic [63:0] DDR_START_ADDR = 64'h0000_0000_8000_0000;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
        logic         awvalid;
        logic         wvalid;
    } axi_wr_reqpkt_t;

    typedef struct packed {
        logic awready;
        logic wready;
    } axi_wr_rdypkt_t;

    typedef struct packed {
        logic [1:0] bresp;
        logic       bvalid;
    } axi_wr_resppkt_t;

    typedef struct packed {
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
    } axi_wr_pld_t;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_ISSUE,
        WS_WAIT_ACK
    } axiwr_slv_st_t;

endpackage

// File: rtl/hawk_sync_fifo.sv
// ---------------------------------------------------------------------------
// hawk_sync_fifo
// Single-clock FIFO with registered storage and a combinational head.
//   clk_i, rst_ni : clock, async active-low reset (empties the FIFO)
//   push_i/data_i : write one entry (caller guarantees not full unless popping)
//   pop_i         : drop the head entry (caller guarantees not empty)
//   head_o        : oldest entry, valid while !empty_o
//   full_o/empty_o/count_o : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module hawk_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [PW:0]      count_q;
    logic [PW:0]      count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read behind the count.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign full_o  = (count_q == FullCount);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/hawk_axiwr_slave.sv
// ---------------------------------------------------------------------------
// hawk_axiwr_slave
// Write-channel responder: queues AW addresses and W data independently,
// pairs them in order, range/alignment-checks each pair and commits legal
// writes to the store port one at a time. One B response per write, in AW
// order; illegal pairs get SLVERR without touching the store port.
//   clk_i, rst_ni : clock, async active-low reset
//   wr_req_i      : {addr, data, strb, awvalid, wvalid}
//   wr_rdy_o      : {awready, wready}
//   wr_resp_o     : {bresp, bvalid}, bready_i pops it
//   mem_valid_o/mem_ready_i/mem_pld_o : store request handshake + payload
//   mem_ack_i     : store committed, one pulse per accepted request
//   ok_cnt_o/err_cnt_o : saturating OKAY / SLVERR response counts
// ---------------------------------------------------------------------------
module hawk_axiwr_slave
    import hacd_pkg::*;
#(
    parameter int          AW_DEPTH = 2,
    parameter int          W_DEPTH  = 2,
    parameter int          B_DEPTH  = 4,
    parameter logic [63:0] WIN_BASE = DDR_START_ADDR,
    parameter logic [63:0] WIN_SIZE = 64'h0040_0000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  axi_wr_reqpkt_t  wr_req_i,
    output axi_wr_rdypkt_t  wr_rdy_o,
    output axi_wr_resppkt_t wr_resp_o,
    input  logic            bready_i,
    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    output axi_wr_pld_t     mem_pld_o,
    input  logic            mem_ack_i,
    output logic [31:0]     ok_cnt_o,
    output logic [31:0]     err_cnt_o
);

    // 65-bit window end so a window touching the top of the address space cannot wrap.
    localparam logic [64:0] WinEnd = {1'b0, WIN_BASE} + {1'b0, WIN_SIZE};

    logic [63:0]  awHead;
    logic [575:0] wHead;
    logic [1:0]   bHead;
    logic         awFull, awEmpty, wFull, wEmpty, bFull, bEmpty;
    logic [$clog2(AW_DEPTH):0] awCount;
    logic [$clog2(W_DEPTH):0]  wCount;
    logic [$clog2(B_DEPTH):0]  bCount;
    logic         unusedCounts;

    logic          awPush, wPush, bPop, pairReady, pairErr;
    logic          pairPop, bPush, latchPld, okInc, errInc;
    logic [1:0]    bPushResp;
    axiwr_slv_st_t state_q, state_d;
    axi_wr_pld_t   pld_q;
    logic [31:0]   okCnt_q, errCnt_q;

    assign awPush = wr_req_i.awvalid && wr_rdy_o.awready;
    assign wPush  = wr_req_i.wvalid && wr_rdy_o.wready;
    assign bPop   = !bEmpty && bready_i;

    // A pair leaves the FIFOs only with a B slot reserved for its response,
    // counting a slot freed by a B pop in the same cycle.
    assign pairReady = !awEmpty && !wEmpty && (!bFull || bPop);

    assign pairErr = (awHead[5:0] != 6'd0) || (awHead < WIN_BASE) ||
                     ({1'b0, awHead} >= WinEnd);

    hawk_sync_fifo #(.WIDTH(64), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .push_i(awPush), .data_i(wr_req_i.addr), .pop_i(pairPop),
        .head_o(awHead), .full_o(awFull), .empty_o(awEmpty), .count_o(awCount)
    );

    hawk_sync_fifo #(.WIDTH(576), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .push_i(wPush), .data_i({wr_req_i.data, wr_req_i.strb}), .pop_i(pairPop),
        .head_o(wHead), .full_o(wFull), .empty_o(wEmpty), .count_o(wCount)
    );

    hawk_sync_fifo #(.WIDTH(2), .DEPTH(B_DEPTH)) u_b_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .push_i(bPush), .data_i(bPushResp), .pop_i(bPop),
        .head_o(bHead), .full_o(bFull), .empty_o(bEmpty), .count_o(bCount)
    );

    assign unusedCounts = ^{awCount, wCount, bCount};

    always_comb begin
        state_d   = state_q;
        pairPop   = 1'b0;
        bPush     = 1'b0;
        bPushResp = BRESP_OKAY;
        latchPld  = 1'b0;
        okInc     = 1'b0;
        errInc    = 1'b0;
        unique case (state_q)
            WS_IDLE: begin
                if (pairReady) begin
                    pairPop = 1'b1;
                    if (pairErr) begin
                        bPush     = 1'b1;
                        bPushResp = BRESP_SLVERR;
                        errInc    = 1'b1;
                    end else begin
                        latchPld = 1'b1;
                        state_d  = WS_ISSUE;
                    end
                end
            end
            WS_ISSUE: begin
                if (mem_ready_i) begin
                    state_d = WS_WAIT_ACK;
                end
            end
            WS_WAIT_ACK: begin
                if (mem_ack_i) begin
                    bPush     = 1'b1;
                    bPushResp = BRESP_OKAY;
                    okInc     = 1'b1;
                    state_d   = WS_IDLE;
                end
            end
            default: state_d = WS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= WS_IDLE;
            pld_q    <= '0;
            okCnt_q  <= '0;
            errCnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (latchPld) begin
                pld_q <= {awHead, wHead};
            end
            if (okInc && (okCnt_q != 32'hFFFF_FFFF)) begin
                okCnt_q <= okCnt_q + 32'd1;
            end
            if (errInc && (errCnt_q != 32'hFFFF_FFFF)) begin
                errCnt_q <= errCnt_q + 32'd1;
            end
        end
    end

    // Readies are forced low while reset is asserted even though the FIFOs read empty.
    assign wr_rdy_o.awready = rst_ni && !awFull;
    assign wr_rdy_o.wready  = rst_ni && !wFull;
    assign wr_resp_o.bvalid = !bEmpty;
    assign wr_resp_o.bresp  = bEmpty ? BRESP_OKAY : bHead;
    assign mem_valid_o      = (state_q == WS_ISSUE);
    assign mem_pld_o        = pld_q;
    assign ok_cnt_o         = okCnt_q;
    assign err_cnt_o        = errCnt_q;

endmodule

// File: tb/tb_hawk_axiwr_slave.sv
// ---------------------------------------------------------------------------
// tb_hawk_axiwr_slave
// Self-checking bench for hawk_axiwr_slave: a vector table of single writes,
// hand-written multi-cycle sequences (reset mid-store, decoupled channels,
// B backpressure) and a randomized run checked against a queue-based model
// of the write rules (in-order B responses, legal writes reach the store).
// ---------------------------------------------------------------------------
module tb_hawk_axiwr_slave;
    import hacd_pkg::*;

    localparam logic [63:0] WIN_BASE   = DDR_START_ADDR;
    localparam logic [63:0] WIN_SIZE   = 64'h0040_0000;
    localparam int          NUM_RANDOM = 2000;

    logic            clk;
    logic            rst_n;
    axi_wr_reqpkt_t  wrReq;
    axi_wr_rdypkt_t  wrRdy;
    axi_wr_resppkt_t wrResp;
    logic            bReady;
    logic            memValid;
    logic            memReady;
    axi_wr_pld_t     memPld;
    logic            memAck;
    logic [31:0]     okCnt;
    logic [31:0]     errCnt;

    hawk_axiwr_slave #(
        .AW_DEPTH(2), .W_DEPTH(2), .B_DEPTH(4),
        .WIN_BASE(WIN_BASE), .WIN_SIZE(WIN_SIZE)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_req_i(wrReq), .wr_rdy_o(wrRdy), .wr_resp_o(wrResp), .bready_i(bReady),
        .mem_valid_o(memValid), .mem_ready_i(memReady), .mem_pld_o(memPld),
        .mem_ack_i(memAck), .ok_cnt_o(okCnt), .err_cnt_o(errCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int assertCount = 0;
    int failCount   = 0;

    // Write stream shared by the cycle-stepped driver and the model.
    logic [63:0]  wAddrList[$];
    logic [511:0] wDataList[$];
    logic [63:0]  wStrbList[$];
    logic [1:0]   expB[$];
    axi_wr_pld_t  expStore[$];
    int expOk, expErr;
    int awIdx, wIdx, awLimit, wLimit, bSeen, storeSeen;
    int awProb, wProb, bProb, memRdyProb, ackMaxDelay;
    bit memWaiting;
    int ackDelay;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] strb;
        logic [1:0]  expBresp;
        bit          expStore;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input logic [639:0] actual,
                               input logic [639:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [511:0] randData();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Reference rule: 64-byte aligned and inside [WIN_BASE, WIN_BASE+WIN_SIZE).
    function automatic bit isLegal(input logic [63:0] a);
        logic [64:0] lo;
        logic [64:0] hi;
        lo = {1'b0, WIN_BASE};
        hi = lo + {1'b0, WIN_SIZE};
        return (a % 64 == 0) && ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    task automatic addWrite(input logic [63:0] a, input logic [511:0] d, input logic [63:0] s);
        axi_wr_pld_t p;
        wAddrList.push_back(a);
        wDataList.push_back(d);
        wStrbList.push_back(s);
        if (isLegal(a)) begin
            p.addr = a;
            p.data = d;
            p.strb = s;
            expStore.push_back(p);
            expB.push_back(BRESP_OKAY);
            expOk++;
        end else begin
            expB.push_back(BRESP_SLVERR);
            expErr++;
        end
    endtask

    task automatic resetDut();
        rst_n    = 1'b0;
        wrReq    = '0;
        bReady   = 1'b0;
        memReady = 1'b0;
        memAck   = 1'b0;
        wAddrList.delete();
        wDataList.delete();
        wStrbList.delete();
        expB.delete();
        expStore.delete();
        expOk = 0; expErr = 0;
        awIdx = 0; wIdx = 0; awLimit = 0; wLimit = 0; bSeen = 0; storeSeen = 0;
        memWaiting = 1'b0;
        ackDelay   = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock of the randomized environment: observe handshakes at the
    // negedge, then drive the next cycle's inputs just after the posedge.
    task automatic stepCycle();
        bit          awFire, wFire, bFire, memFire;
        logic [1:0]  expResp;
        axi_wr_pld_t expPld;
        @(negedge clk);
        awFire  = wrReq.awvalid && wrRdy.awready;
        wFire   = wrReq.wvalid && wrRdy.wready;
        bFire   = wrResp.bvalid && bReady;
        memFire = memValid && memReady;
        if (bFire) begin
            expResp = (expB.size() > 0) ? expB.pop_front() : 2'b11;
            checkOutput("bOrder", wrResp.bresp, expResp);
            bSeen++;
        end
        if (memFire) begin
            expPld = (expStore.size() > 0) ? expStore.pop_front() : '1;
            checkOutput("storePayload", memPld, expPld);
            storeSeen++;
            memWaiting = 1'b1;
            ackDelay   = $urandom_range(0, ackMaxDelay);
        end
        @(posedge clk);
        #1;
        if (awFire) awIdx++;
        if (wFire) wIdx++;
        if (awIdx >= awLimit) wrReq.awvalid = 1'b0;
        else if (!wrReq.awvalid || awFire) wrReq.awvalid = (int'($urandom_range(0, 99)) < awProb);
        if (awIdx < awLimit) wrReq.addr = wAddrList[awIdx];
        if (wIdx >= wLimit) wrReq.wvalid = 1'b0;
        else if (!wrReq.wvalid || wFire) wrReq.wvalid = (int'($urandom_range(0, 99)) < wProb);
        if (wIdx < wLimit) begin
            wrReq.data = wDataList[wIdx];
            wrReq.strb = wStrbList[wIdx];
        end
        bReady = (int'($urandom_range(0, 99)) < bProb);
        memAck = 1'b0;
        if (memWaiting) begin
            memReady = 1'b0;
            if (ackDelay == 0) begin
                memAck     = 1'b1;
                memWaiting = 1'b0;
            end else begin
                ackDelay--;
            end
        end else begin
            memReady = (int'($urandom_range(0, 99)) < memRdyProb);
        end
    endtask

    // Single write from the vector table: AW and W together, store port
    // accepts one cycle after valid, ack two cycles after acceptance.
    task automatic applyStimulus(input vec_t v, input logic [511:0] d);
        bit          sawStore = 1'b0;
        bit          gotResp  = 1'b0;
        axi_wr_pld_t seenPld  = '0;
        logic [1:0]  seenResp = 2'b11;
        bReady        = 1'b1;
        wrReq.addr    = v.addr;
        wrReq.data    = d;
        wrReq.strb    = v.strb;
        wrReq.awvalid = 1'b1;
        wrReq.wvalid  = 1'b1;
        @(posedge clk);
        #1;
        wrReq.awvalid = 1'b0;
        wrReq.wvalid  = 1'b0;
        for (int c = 0; c < 20 && !gotResp; c++) begin
            @(negedge clk);
            if (wrResp.bvalid) begin
                gotResp  = 1'b1;
                seenResp = wrResp.bresp;
            end else if (memValid && !sawStore) begin
                sawStore = 1'b1;
                seenPld  = memPld;
                @(posedge clk); #1 memReady = 1'b1;
                @(posedge clk); #1 memReady = 1'b0;
                @(negedge clk);
                checkOutput("validDrop", memValid, 1'b0);
                @(posedge clk);
                @(posedge clk); #1 memAck = 1'b1;
                @(posedge clk); #1 memAck = 1'b0;
            end
        end
        checkOutput("storeIssued", sawStore, v.expStore);
        if (v.expStore) checkOutput("tablePayload", seenPld, {v.addr, d, v.strb});
        checkOutput("respSeen", gotResp, 1'b1);
        checkOutput("tableBresp", seenResp, v.expBresp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0]  a;
        logic [511:0] d;
        logic [63:0]  s;
        int           cyc;

        vecs[0] = '{WIN_BASE + 64'h40,            '1,    BRESP_OKAY,   1'b1};
        vecs[1] = '{WIN_BASE + 64'h8,             '1,    BRESP_SLVERR, 1'b0};
        vecs[2] = '{WIN_BASE + WIN_SIZE,          '1,    BRESP_SLVERR, 1'b0};
        vecs[3] = '{WIN_BASE,                     64'h0F0F_0000_FFFF_0001, BRESP_OKAY, 1'b1};
        vecs[4] = '{WIN_BASE + WIN_SIZE - 64'h40, '1,    BRESP_OKAY,   1'b1};
        vecs[5] = '{WIN_BASE - 64'h40,            '1,    BRESP_SLVERR, 1'b0};
        vecs[6] = '{WIN_BASE + 64'h100,           64'h0, BRESP_OKAY,   1'b1};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFC0,      '1,    BRESP_SLVERR, 1'b0};
        vecs[8] = '{WIN_BASE + 64'h41,            '1,    BRESP_SLVERR, 1'b0};
        vecs[9] = '{WIN_BASE + 64'h20,            '1,    BRESP_SLVERR, 1'b0};

        awProb = 100; wProb = 100; bProb = 100; memRdyProb = 0; ackMaxDelay = 0;

        // Reset asserted while a legal write sits in ISSUE.
        $display("[TB] reset mid-store");
        resetDut();
        addWrite(WIN_BASE + 64'h80, randData(), '1);
        awLimit = 1; wLimit = 1;
        for (int c = 0; c < 10 && !memValid; c++) stepCycle();
        checkOutput("reachIssue", memValid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstMemValid", memValid, 1'b0);
        checkOutput("rstMemPld", memPld, '0);
        checkOutput("rstRdy", wrRdy, 2'b00);
        checkOutput("rstResp", wrResp, 3'b000);
        checkOutput("rstOkCnt", okCnt, 32'd0);
        checkOutput("rstErrCnt", errCnt, 32'd0);
        resetDut();
        @(negedge clk);
        checkOutput("postRstRdy", wrRdy, 2'b11);
        checkOutput("postRstBvalid", wrResp.bvalid, 1'b0);
        @(posedge clk); #1 memAck = 1'b1;
        @(posedge clk); #1 memAck = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("lateAckBvalid", wrResp.bvalid, 1'b0);
        checkOutput("lateAckOkCnt", okCnt, 32'd0);
        checkOutput("lateAckMemValid", memValid, 1'b0);

        // Table of single writes, legal and illegal.
        $display("[TB] vector table");
        resetDut();
        foreach (vecs[i]) applyStimulus(vecs[i], randData());
        checkOutput("tableOkCnt", okCnt, 32'd4);
        checkOutput("tableErrCnt", errCnt, 32'd6);

        // AW runs ahead of W; the third AW must wait for the first pair to pop.
        $display("[TB] decoupled channels");
        resetDut();
        memRdyProb = 100; ackMaxDelay = 1;
        addWrite(WIN_BASE + 64'h10, randData(), '1);
        addWrite(WIN_BASE + 64'h80, randData(), '1);
        addWrite(WIN_BASE + 64'hC0, randData(), 64'h00FF);
        awLimit = 2;
        repeat (12) stepCycle();
        checkOutput("aheadAwIdx", awIdx, 2);
        checkOutput("aheadAwReady", wrRdy.awready, 1'b0);
        checkOutput("aheadNoB", bSeen, 0);
        awLimit = 3;
        repeat (5) stepCycle();
        checkOutput("thirdAwStall", awIdx, 2);
        wLimit = 3;
        for (int c = 0; c < 60 && bSeen < 3; c++) stepCycle();
        checkOutput("decoupledB", bSeen, 3);
        checkOutput("decoupledAw", awIdx, 3);
        checkOutput("decoupledOk", okCnt, 32'd2);
        checkOutput("decoupledErr", errCnt, 32'd1);

        // B backpressure: only B_DEPTH responses may queue.
        $display("[TB] B backpressure");
        resetDut();
        bProb = 0;
        for (int i = 0; i < 5; i++) addWrite(WIN_BASE + 64'h8 + 64'(i), randData(), '1);
        awLimit = 5; wLimit = 5;
        repeat (20) stepCycle();
        checkOutput("bpErrCnt", errCnt, 32'd4);
        checkOutput("bpBvalid", wrResp.bvalid, 1'b1);
        checkOutput("bpAwIdx", awIdx, 5);
        checkOutput("bpNoPop", bSeen, 0);
        bProb = 100;
        for (int c = 0; c < 50 && bSeen < 5; c++) stepCycle();
        repeat (5) stepCycle();
        checkOutput("bpAllB", bSeen, 5);
        checkOutput("bpErrCntFinal", errCnt, 32'd5);
        checkOutput("bpDrained", wrResp.bvalid, 1'b0);

        // Randomized mix against the model.
        $display("[TB] random run");
        resetDut();
        awProb = 60; wProb = 60; bProb = 70; memRdyProb = 50; ackMaxDelay = 3;
        for (int i = 0; i < NUM_RANDOM; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = WIN_BASE + 64'($urandom_range(0, 65535)) * 64;
                6: a = WIN_BASE + 64'($urandom_range(0, 65535)) * 64 + 64'($urandom_range(1, 63));
                7: a = WIN_BASE + WIN_SIZE + 64'($urandom_range(0, 1000)) * 64;
                8: a = WIN_BASE - 64'($urandom_range(1, 1000)) * 64;
                default: a = {$urandom, $urandom} & ~64'h3F;
            endcase
            d = randData();
            s = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
            addWrite(a, d, s);
        end
        awLimit = NUM_RANDOM; wLimit = NUM_RANDOM;
        cyc = 0;
        while (bSeen < NUM_RANDOM && cyc < 40000) begin
            stepCycle();
            cyc++;
        end
        checkOutput("rndAllB", bSeen, NUM_RANDOM);
        checkOutput("rndCntSum", okCnt + errCnt, 32'(NUM_RANDOM));
        checkOutput("rndOkCnt", okCnt, 32'(expOk));
        checkOutput("rndErrCnt", errCnt, 32'(expErr));
        checkOutput("rndStores", storeSeen, expOk);
        checkOutput("rndStoreLeft", expStore.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
